// File: rtl/mac_share_pkg.sv
// mac_share_pkg: shared state encoding, sizes and round-robin pick for the MAC arbiter
package mac_share_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int NREQ = 2;
  localparam int OP_W = 8;
  // Under contention the requester that was not served last wins; otherwise the lone requester.
  function automatic logic pick(input logic [NREQ-1:0] req, input logic last_grant);
    return (&req) ? ~last_grant : req[1];
  endfunction
endpackage

// File: rtl/mac_accum_unit.sv
// mac_accum_unit: 8x8 unsigned multiply feeding a wrapping accumulator with sticky carry
module mac_accum_unit
  import mac_share_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);
  logic [2*OP_W-1:0] prod;
  logic [ACC_W:0] sum;
  assign prod = a * b;
  assign sum = {1'b0, acc} + {{(ACC_W + 1 - 2 * OP_W){1'b0}}, prod};
  // Clear wins over enable so a fresh job always starts from zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (enable) begin
      acc <= sum[ACC_W-1:0];
      ovf <= ovf | sum[ACC_W];
    end
  end
endmodule

// File: rtl/mac_share_arbiter.sv
// mac_share_arbiter: round-robin sharing of one MAC datapath between two dot-product requesters
module mac_share_arbiter
  import mac_share_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int ACC_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [2*LEN_W-1:0]    len,
  input  logic [NREQ-1:0]       op_valid,
  input  logic [2*OP_W-1:0]     op_a,
  input  logic [2*OP_W-1:0]     op_b,
  output logic [NREQ-1:0]       op_ready,
  output logic [NREQ-1:0]       res_valid,
  output logic [ACC_W-1:0]      res_data,
  output logic                  res_ovf,
  input  logic [NREQ-1:0]       res_ready,
  output logic                  busy,
  output logic                  grant_id
);
  state_t state, state_n;
  logic g, last_grant, gn, hs;
  logic [LEN_W-1:0] len_q, count, len_sel;
  logic [OP_W-1:0] a_sel, b_sel;
  logic [NREQ-1:0] onehot;
  logic [ACC_W-1:0] acc;
  logic ovf;
  assign gn = pick(req, last_grant);
  assign len_sel = gn ? len[2*LEN_W-1:LEN_W] : len[LEN_W-1:0];
  assign a_sel = g ? op_a[2*OP_W-1:OP_W] : op_a[OP_W-1:0];
  assign b_sel = g ? op_b[2*OP_W-1:OP_W] : op_b[OP_W-1:0];
  assign onehot = g ? 2'b10 : 2'b01;
  assign hs = (state == RUN) && op_valid[g];
  assign grant_id = g;
  mac_accum_unit #(.ACC_W(ACC_W)) u_mac (
    .clk(clk),
    .rst(rst),
    .clear(state == IDLE),
    .enable(hs),
    .a(a_sel),
    .b(b_sel),
    .acc(acc),
    .ovf(ovf)
  );
  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // Next state: dropping req aborts a job from RUN or DONE back to IDLE.
  always_comb begin
    state_n = state;
    if (state == IDLE) begin
      if (|req) state_n = (len_sel == '0) ? DONE : RUN;
    end else if (!req[g]) state_n = IDLE;
    else if (state == RUN) begin
      if (hs && (count + LEN_W'(1) == len_q)) state_n = DONE;
    end else if (res_ready[g]) state_n = IDLE;
  end
  // Grant, job length and pair count; last_grant updates whenever a job ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      g <= 1'b1;
      last_grant <= 1'b1;
      len_q <= '0;
      count <= '0;
    end else begin
      if (state == IDLE && |req) begin
        g <= gn;
        len_q <= len_sel;
        count <= '0;
      end
      if (hs) count <= count + LEN_W'(1);
      if (state != IDLE && state_n == IDLE) last_grant <= g;
    end
  end
  // Outputs are decoded from the state; result lines read zero outside DONE.
  always_comb begin
    op_ready = (state == RUN) ? onehot : '0;
    res_valid = (state == DONE) ? onehot : '0;
    res_data = (state == DONE) ? acc : '0;
    res_ovf = (state == DONE) && ovf;
    busy = state != IDLE;
  end
endmodule
